// File: rtl/adcmux_seq.sv
// Scans enabled ADC channels: drives mux selects, waits settle time, pulses start, captures result.
// Latency: selects 1 cycle after selection; start after max(settle_cyc,1) cycles; result 1 cycle after adc_done.
// Backpressure: result held on res_valid until res_ready; no new channel is selected before acceptance.
module adcmux_seq #(
  parameter int DATA_W   = 12,
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [3:0]          chmask,
  input  logic [SETTLE_W-1:0] settle_cyc,
  output logic                mux_msb,
  output logic                mux_lsb,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [DATA_W-1:0]   adc_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [1:0]          res_ch,
  output logic [DATA_W-1:0]   res_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, OUTPUT} state_t;

  state_t              state, state_n;
  logic [1:0]          ptr, ptr_n;
  logic [1:0]          ch, ch_n;
  logic [SETTLE_W-1:0] cnt, cnt_n;
  logic                adc_start_n, res_valid_n, busy_n;
  logic [1:0]          res_ch_n;
  logic [DATA_W-1:0]   res_data_n;
  logic [1:0]          scan_base, pick;
  logic                pick_vld, do_sel;

  assign {mux_msb, mux_lsb} = ch;

  // On acceptance the scan restarts just past the channel being retired.
  always_comb begin
    scan_base = (state == OUTPUT) ? ch + 2'd1 : ptr;
    pick      = scan_base;
    pick_vld  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (chmask[scan_base + 2'(i)]) begin
        pick     = scan_base + 2'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    ch_n        = ch;
    cnt_n       = cnt;
    adc_start_n = 1'b0;
    res_valid_n = res_valid;
    res_ch_n    = res_ch;
    res_data_n  = res_data;
    do_sel      = 1'b0;
    case (state)
      IDLE: begin
        if (en && pick_vld) do_sel = 1'b1;
      end
      SETTLE: begin
        if (cnt <= SETTLE_W'(1)) begin
          state_n     = CONVERT;
          adc_start_n = 1'b1;
        end else begin
          cnt_n = cnt - SETTLE_W'(1);
        end
      end
      CONVERT: begin
        if (adc_done) begin
          res_data_n  = adc_data;
          res_ch_n    = ch;
          res_valid_n = 1'b1;
          state_n     = OUTPUT;
        end
      end
      OUTPUT: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          ptr_n       = ch + 2'd1;
          if (en && pick_vld) do_sel = 1'b1;
          else                state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (do_sel) begin
      ch_n    = pick;
      cnt_n   = settle_cyc;
      state_n = SETTLE;
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      ch        <= 2'd0;
      cnt       <= '0;
      adc_start <= 1'b0;
      res_valid <= 1'b0;
      res_ch    <= 2'd0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      ch        <= ch_n;
      cnt       <= cnt_n;
      adc_start <= adc_start_n;
      res_valid <= res_valid_n;
      res_ch    <= res_ch_n;
      res_data  <= res_data_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_adcmux_seq.sv
// Directed bench for adcmux_seq: table of scan steps plus hand sequences for stall, mask change, en drop, reset.
module tb_adcmux_seq;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  chmask;
  logic [7:0]  settle_cyc;
  logic        mux_msb, mux_lsb, adc_start, adc_done;
  logic [11:0] adc_data;
  logic        res_valid, res_ready, busy;
  logic [1:0]  res_ch;
  logic [11:0] res_data;
  logic [1:0]  sel;

  logic        adc_done_m, man_done;
  logic [11:0] adc_data_m, man_data;

  int total = 0;
  int passed = 0;

  assign sel      = {mux_msb, mux_lsb};
  assign adc_done = adc_done_m | man_done;
  assign adc_data = man_done ? man_data : adc_data_m;

  adcmux_seq #(.DATA_W(12), .SETTLE_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .chmask(chmask), .settle_cyc(settle_cyc),
    .mux_msb(mux_msb), .mux_lsb(mux_lsb), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_data(res_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model_val(input logic [1:0] c);
    case (c)
      2'd0:    return 12'h5A1;
      2'd1:    return 12'hC32;
      2'd2:    return 12'h0F3;
      default: return 12'h964;
    endcase
  endfunction

  // ADC model: adc_done five cycles after adc_start, value depends on the channel selected at start.
  initial begin
    int          cnt_m;
    logic [1:0]  start_sel;
    cnt_m      = 0;
    start_sel  = 2'd0;
    adc_done_m = 1'b0;
    adc_data_m = 12'h000;
    forever begin
      @(negedge clk);
      adc_done_m = 1'b0;
      if (cnt_m > 0) begin
        cnt_m--;
        if (cnt_m == 0) begin
          adc_done_m = 1'b1;
          adc_data_m = model_val(start_sel);
        end
      end
      if (adc_start) begin
        cnt_m     = 5;
        start_sel = sel;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!adc_start && n < 300) begin
      tick();
      n++;
    end
  endtask

  // Called in the adc_start cycle; returns cycles until res_valid.
  task automatic wait_valid(output int n);
    tick();
    check("start_width", 32'(adc_start), 32'd0);
    n = 1;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [7:0] settle;
    logic [1:0] ch;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    int exp_settle;
    reset = 1'b1; en = 1'b0; chmask = 4'b0000; settle_cyc = 8'd0;
    res_ready = 1'b0; man_done = 1'b0; man_data = 12'h000;

    vecs[0]  = '{4'b1111, 8'd3, 2'd0};
    vecs[1]  = '{4'b1111, 8'd3, 2'd1};
    vecs[2]  = '{4'b1111, 8'd3, 2'd2};
    vecs[3]  = '{4'b1111, 8'd3, 2'd3};
    vecs[4]  = '{4'b1111, 8'd3, 2'd0};
    vecs[5]  = '{4'b1010, 8'd0, 2'd1};
    vecs[6]  = '{4'b1010, 8'd0, 2'd3};
    vecs[7]  = '{4'b1010, 8'd0, 2'd1};
    vecs[8]  = '{4'b0110, 8'd1, 2'd2};
    vecs[9]  = '{4'b0110, 8'd1, 2'd1};
    vecs[10] = '{4'b1000, 8'd2, 2'd3};
    vecs[11] = '{4'b1000, 8'd2, 2'd3};

    tick(); tick();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_start", 32'(adc_start), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_ch", 32'(res_ch), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    reset = 1'b0;
    en = 1'b1;
    chmask = 4'b0000;
    tick(); tick();
    check("zero_mask_busy", 32'(busy), 32'd0);

    // Table-driven scan steps: each record is applied just before its selection edge.
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chmask     = vecs[i].mask;
      settle_cyc = vecs[i].settle;
      exp_settle = (vecs[i].settle == 8'd0) ? 1 : int'(vecs[i].settle);
      tick();
      check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].ch));
      check($sformatf("v%0d_valid_low", i), 32'(res_valid), 32'd0);
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_start(n);
      check($sformatf("v%0d_settle", i), 32'(n), 32'(exp_settle));
      check($sformatf("v%0d_sel_hold", i), 32'(sel), 32'(vecs[i].ch));
      wait_valid(n);
      check($sformatf("v%0d_lat", i), 32'(n), 32'd6);
      check($sformatf("v%0d_res_ch", i), 32'(res_ch), 32'(vecs[i].ch));
      check($sformatf("v%0d_res_data", i), 32'(res_data), 32'(model_val(vecs[i].ch)));
    end

    // Backpressure on the channel 3 result.
    res_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_res_ch", 32'(res_ch), 32'd3);
      check("bp_res_data", 32'(res_data), 32'(model_val(2'd3)));
      check("bp_start", 32'(adc_start), 32'd0);
      check("bp_sel", 32'(sel), 32'd3);
    end
    chmask = 4'b0001; settle_cyc = 8'd4; res_ready = 1'b1;
    tick();
    check("bp_accept_sel", 32'(sel), 32'd0);
    check("bp_accept_valid", 32'(res_valid), 32'd0);

    // Mask change mid-SETTLE: channel 0 finishes, next selection uses the new mask.
    tick();
    chmask = 4'b0100;
    wait_start(n);
    check("mc_settle", 32'(n), 32'd3);
    check("mc_sel", 32'(sel), 32'd0);
    wait_valid(n);
    check("mc_res_ch", 32'(res_ch), 32'd0);
    tick();
    check("mc_next_sel", 32'(sel), 32'd2);

    // en dropped during CONVERT: result still delivered, then idle.
    wait_start(n);
    en = 1'b0;
    wait_valid(n);
    check("en_valid", 32'(res_valid), 32'd1);
    check("en_res_ch", 32'(res_ch), 32'd2);
    check("en_res_data", 32'(res_data), 32'(model_val(2'd2)));
    tick();
    check("en_idle_busy", 32'(busy), 32'd0);
    check("en_idle_valid", 32'(res_valid), 32'd0);
    check("en_idle_sel", 32'(sel), 32'd2);
    man_done = 1'b1; man_data = 12'hABC;
    tick();
    man_done = 1'b0;
    tick();
    check("idle_done_valid", 32'(res_valid), 32'd0);
    check("idle_done_busy", 32'(busy), 32'd0);

    // Reset mid-CONVERT with adc_done arriving the following cycle.
    en = 1'b1; chmask = 4'b0010; settle_cyc = 8'd2;
    tick();
    check("rc_sel", 32'(sel), 32'd1);
    wait_start(n);
    check("rc_start", 32'(adc_start), 32'd1);
    reset = 1'b1; en = 1'b0;
    tick();
    reset = 1'b0;
    man_done = 1'b1; man_data = 12'hFFF;
    check("rc_sel0", 32'(sel), 32'd0);
    check("rc_start0", 32'(adc_start), 32'd0);
    check("rc_valid0", 32'(res_valid), 32'd0);
    check("rc_busy0", 32'(busy), 32'd0);
    check("rc_res_ch0", 32'(res_ch), 32'd0);
    check("rc_res_data0", 32'(res_data), 32'd0);
    tick();
    man_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("rc_no_result", 32'(res_valid), 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
